// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-port memory between the fetch port and the load/store port.
// Define ARB_PERF_EN to add saturating stall-cycle counters (perf_if_stall, perf_d_stall).
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_EN
    ,
    output logic [31:0]       perf_if_stall,
    output logic [31:0]       perf_d_stall
`endif
);

    typedef enum logic [1:0] {IDLE, IF_ACC, D_ACC} state_t;

    localparam logic [3:0] LAT_LAST   = 4'(MEM_LAT - 1);
    localparam logic [3:0] STREAK_MAX = 4'(STARVE_MAX);

    state_t            state_q;
    logic [3:0]        lat_cnt_q;
    logic [3:0]        d_streak_q;
    logic              sel_we_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              if_valid_q;
    logic              d_valid_q;
    logic              d_req;

    assign d_req = d_rd | d_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lat_cnt_q  <= '0;
            d_streak_q <= '0;
            sel_we_q   <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
        end else begin
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Requests seen during a valid pulse are the ones just served, so no grant then.
                    if (!if_valid_q && !d_valid_q) begin
                        if (if_req && (!d_req || d_streak_q == STREAK_MAX)) begin
                            state_q    <= IF_ACC;
                            d_streak_q <= '0;
                            addr_q     <= if_addr;
                            sel_we_q   <= 1'b0;
                            mem_en_q   <= 1'b1;
                            lat_cnt_q  <= '0;
                        end else if (d_req) begin
                            state_q    <= D_ACC;
                            addr_q     <= d_addr;
                            wdata_q    <= d_wdata;
                            sel_we_q   <= d_wr;
                            mem_we_q   <= d_wr;
                            mem_en_q   <= 1'b1;
                            lat_cnt_q  <= '0;
                            if (!if_req) begin
                                d_streak_q <= '0;
                            end else if (d_streak_q != STREAK_MAX) begin
                                d_streak_q <= d_streak_q + 4'd1;
                            end
                        end
                    end
                end
                IF_ACC, D_ACC: begin
                    lat_cnt_q <= lat_cnt_q + 4'd1;
                    if (lat_cnt_q == LAT_LAST) begin
                        state_q <= IDLE;
                        if (state_q == IF_ACC) begin
                            if_rdata_q <= mem_rdata;
                            if_valid_q <= 1'b1;
                        end else begin
                            if (!sel_we_q) begin
                                d_rdata_q <= mem_rdata;
                            end
                            d_valid_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign d_rdata   = d_rdata_q;
    assign d_valid   = d_valid_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign stall_if  = if_req & ~if_valid_q;
    assign stall_mem = d_req & ~d_valid_q;

`ifdef ARB_PERF_EN
    logic [31:0] perf_if_q;
    logic [31:0] perf_d_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_if_q <= '0;
            perf_d_q  <= '0;
        end else begin
            if (stall_if && perf_if_q != 32'hFFFF_FFFF) begin
                perf_if_q <= perf_if_q + 32'd1;
            end
            if (stall_mem && perf_d_q != 32'hFFFF_FFFF) begin
                perf_d_q <= perf_d_q + 32'd1;
            end
        end
    end

    assign perf_if_stall = perf_if_q;
    assign perf_d_stall  = perf_d_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic checked every cycle
// against a transaction-schedule model with a shadow memory.
module tb_mem_port_arbiter;
    localparam int LAT  = 2;
    localparam int SMAX = 4;
    localparam logic [31:0] JUNK = 32'hBADC_0DE5;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          wr;
        bit          both;
        int          gap;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_rd;
    logic        d_wr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        stall_if;
    logic        stall_mem;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef ARB_PERF_EN
    logic [31:0] perf_if_stall;
    logic [31:0] perf_d_stall;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef ARB_PERF_EN
        , .perf_if_stall(perf_if_stall), .perf_d_stall(perf_d_stall)
`endif
    );

    // Environment memory: data appears LAT-1 cycles after the mem_en cycle, junk otherwise.
    logic [31:0] env_mem [64];
    int          rd_k = 0;
    logic [31:0] rd_addr = '0;

    always @(posedge clk) begin
        if (mem_en) begin
            rd_k    <= 1;
            rd_addr <= mem_addr;
        end else if (rd_k > 0 && rd_k < 15) begin
            rd_k <= rd_k + 1;
        end
    end

    always_comb begin
        if (LAT == 1) mem_rdata = mem_en ? env_mem[mem_addr[7:2]] : JUNK;
        else          mem_rdata = (rd_k == LAT - 1) ? env_mem[rd_addr[7:2]] : JUNK;
    end

    // Model state and bookkeeping, all owned by the main process.
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] shadow [64];
    bit          acc_act = 0, acc_d = 0, acc_we = 0;
    int          acc_t = 0;
    logic [31:0] acc_addr = '0, acc_wdata = '0, acc_data = '0;
    int          streak = 0;
    logic [31:0] e_if_rdata = '0, e_d_rdata = '0;
    bit          if_done = 0, d_done = 0, if_active = 0, d_active = 0;
    txn_t        if_q[$];
    txn_t        d_q[$];
    int          en_cyc, ifv_cyc, dv_cyc, stall_if_cnt, stall_d_cnt;
    logic [31:0] en_addr, en_wdata, ifv_data, dv_data;
    logic        en_we;
    logic [31:0] en_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_logs();
        en_cyc = -100; ifv_cyc = -100; dv_cyc = -100;
        stall_if_cnt = 0; stall_d_cnt = 0;
        en_addr = '0; en_wdata = '0; en_we = 1'b0; ifv_data = '0; dv_data = '0;
        en_q.delete();
    endtask

    task automatic compare();
        bit e_en, e_ifv, e_dv;
        bit wi, wd;
        e_en  = acc_act && (cyc == acc_t + 1);
        e_ifv = acc_act && !acc_d && (cyc == acc_t + 1 + LAT);
        e_dv  = acc_act && acc_d && (cyc == acc_t + 1 + LAT);
        if (e_ifv) e_if_rdata = acc_data;
        if (e_dv && !acc_we) e_d_rdata = acc_data;

        chk("mem_en", 32'(mem_en), 32'(e_en));
        chk("mem_we", 32'(mem_we), 32'(e_en && acc_we));
        if (e_en) begin
            chk("mem_addr", mem_addr, acc_addr);
            if (acc_we) chk("mem_wdata", mem_wdata, acc_wdata);
        end
        chk("if_valid", 32'(if_valid), 32'(e_ifv));
        chk("d_valid", 32'(d_valid), 32'(e_dv));
        chk("if_rdata", if_rdata, e_if_rdata);
        chk("d_rdata", d_rdata, e_d_rdata);
        chk("stall_if", 32'(stall_if), 32'(if_req && !e_ifv));
        chk("stall_mem", 32'(stall_mem), 32'((d_rd || d_wr) && !e_dv));

        if (mem_en) begin
            en_cyc = cyc; en_addr = mem_addr; en_we = mem_we; en_wdata = mem_wdata;
            en_q.push_back(mem_addr);
            if (mem_we) env_mem[mem_addr[7:2]] = mem_wdata;
        end
        if (if_valid) begin ifv_cyc = cyc; ifv_data = if_rdata; end
        if (d_valid) begin dv_cyc = cyc; dv_data = d_rdata; end
        if (stall_if) stall_if_cnt++;
        if (stall_mem) stall_d_cnt++;

        if_done = e_ifv;
        d_done  = e_dv;
        if (e_ifv || e_dv) acc_act = 0;

        if (rst) begin
            acc_act = 0; streak = 0; e_if_rdata = '0; e_d_rdata = '0;
        end else if (!acc_act && !(e_ifv || e_dv)) begin
            wi = if_req;
            wd = d_rd || d_wr;
            if (wi && (!wd || streak == SMAX)) begin
                acc_act = 1; acc_t = cyc; acc_d = 0; acc_we = 0;
                acc_addr = if_addr;
                acc_data = shadow[if_addr[7:2]];
                streak = 0;
            end else if (wd) begin
                acc_act = 1; acc_t = cyc; acc_d = 1; acc_we = d_wr;
                acc_addr = d_addr; acc_wdata = d_wdata;
                if (d_wr) shadow[d_addr[7:2]] = d_wdata;
                else acc_data = shadow[d_addr[7:2]];
                if (!wi) streak = 0;
                else if (streak < SMAX) streak++;
            end
        end
    endtask

    task automatic step(input bit do_rst);
        txn_t t;
        @(negedge clk);
        rst = do_rst;
        if (do_rst) begin
            if_active = 0; d_active = 0;
            if_req = 0; d_rd = 0; d_wr = 0;
            if_done = 0; d_done = 0;
        end else begin
            if (if_active && if_done) begin
                if_active = 0; if_req = 0; if_addr = $urandom;
            end
            if (!if_active && if_q.size() > 0) begin
                t = if_q[0];
                if (t.gap > 0) begin
                    t.gap--; if_q[0] = t;
                end else begin
                    void'(if_q.pop_front());
                    if_active = 1; if_req = 1; if_addr = t.addr;
                end
            end
            if (d_active && d_done) begin
                d_active = 0; d_rd = 0; d_wr = 0; d_addr = $urandom; d_wdata = $urandom;
            end
            if (!d_active && d_q.size() > 0) begin
                t = d_q[0];
                if (t.gap > 0) begin
                    t.gap--; d_q[0] = t;
                end else begin
                    void'(d_q.pop_front());
                    d_active = 1; d_rd = !t.wr || t.both; d_wr = t.wr;
                    d_addr = t.addr; d_wdata = t.wdata;
                end
            end
        end
        #1;
        compare();
        cyc++;
    endtask

    task automatic push_if(input logic [31:0] a, input int g);
        txn_t t;
        t.addr = a; t.wdata = '0; t.wr = 0; t.both = 0; t.gap = g;
        if_q.push_back(t);
    endtask

    task automatic push_d(input logic [31:0] a, input bit wr, input bit both,
                          input logic [31:0] wd, input int g);
        txn_t t;
        t.addr = a; t.wdata = wd; t.wr = wr; t.both = both; t.gap = g;
        d_q.push_back(t);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((acc_act || if_active || d_active || if_q.size() > 0 || d_q.size() > 0) && n < 400) begin
            step(0);
            n++;
        end
        if (n >= 400) chk({name, "_idle_timeout"}, 32'(n), 32'd0);
        step(0);
    endtask

    initial begin
        int s;
        int n;
        logic [31:0] v;
        rst = 1'b1; if_req = 0; d_rd = 0; d_wr = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        for (int i = 0; i < 64; i++) begin
            v = $urandom;
            env_mem[i] = v;
            shadow[i]  = v;
        end
        env_mem[4] = 32'h00A0_0093; shadow[4] = 32'h00A0_0093;
        env_mem[8] = 32'h1234_5678; shadow[8] = 32'h1234_5678;
        clear_logs();

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_d_valid", 32'(d_valid), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);

        // Fetch alone from 0x10.
        clear_logs(); s = cyc;
        push_if(32'h10, 0);
        wait_idle("s1");
        chk("s1_en_lat", 32'(en_cyc - s), 32'd1);
        chk("s1_en_addr", en_addr, 32'h10);
        chk("s1_en_we", 32'(en_we), 32'd0);
        chk("s1_valid_lat", 32'(ifv_cyc - s), 32'd3);
        chk("s1_if_rdata", ifv_data, 32'h00A0_0093);
        chk("s1_stall_cycles", 32'(stall_if_cnt), 32'd3);

        // Fetch and load raised together: data first.
        clear_logs(); s = cyc;
        push_if(32'h14, 0);
        push_d(32'h20, 0, 0, '0, 0);
        wait_idle("s2");
        chk("s2_first_grant", (en_q.size() > 0) ? en_q[0] : 32'hFFFF_FFFF, 32'h20);
        chk("s2_second_grant", (en_q.size() > 1) ? en_q[1] : 32'hFFFF_FFFF, 32'h14);
        chk("s2_d_valid_lat", 32'(dv_cyc - s), 32'd3);
        chk("s2_d_rdata", dv_data, 32'h1234_5678);
        chk("s2_stall_mem_cycles", 32'(stall_d_cnt), 32'd3);
        chk("s2_stall_if_cycles", 32'(stall_if_cnt), 32'd7);

        // Store, then read it back.
        clear_logs(); s = cyc;
        push_d(32'h40, 1, 0, 32'hDEAD_BEEF, 0);
        wait_idle("s3");
        chk("s3_en_we", 32'(en_we), 32'd1);
        chk("s3_en_addr", en_addr, 32'h40);
        chk("s3_en_wdata", en_wdata, 32'hDEAD_BEEF);
        chk("s3_d_valid_lat", 32'(dv_cyc - s), 32'd3);
        chk("s3_d_rdata_kept", d_rdata, 32'h1234_5678);
        push_d(32'h40, 0, 0, '0, 0);
        wait_idle("s3b");
        chk("s3_readback", dv_data, 32'hDEAD_BEEF);

        // Fetch held against back-to-back loads: four data grants, then fetch.
        clear_logs();
        push_if(32'h10, 0);
        for (int i = 0; i < 6; i++) push_d(32'h80 + 32'(4 * i), 0, 0, '0, 0);
        wait_idle("s4");
        chk("s4_grant_count", 32'(en_q.size()), 32'd7);
        if (en_q.size() == 7) begin
            chk("s4_grant3", en_q[3], 32'h8C);
            chk("s4_grant4", en_q[4], 32'h10);
            chk("s4_grant5", en_q[5], 32'h90);
        end

        // Reset during the second access cycle of a load.
        clear_logs();
        push_d(32'hA0, 0, 0, '0, 0);
        n = 0;
        while (!acc_act && n < 20) begin step(0); n++; end
        if (n >= 20) chk("s5_grant_timeout", 32'(n), 32'd0);
        step(0);
        step(1);
        step(0);
        chk("s5_d_valid", 32'(d_valid), 32'd0);
        chk("s5_mem_en", 32'(mem_en), 32'd0);
        chk("s5_mem_we", 32'(mem_we), 32'd0);
        chk("s5_d_rdata", d_rdata, 32'd0);
        chk("s5_if_rdata", if_rdata, 32'd0);
        chk("s5_mem_addr", mem_addr, 32'd0);
        chk("s5_mem_wdata", mem_wdata, 32'd0);
        step(0);
        chk("s5_no_late_valid", 32'(d_valid), 32'd0);

        // Random traffic.
        for (int c = 0; c < 900; c++) begin
            if (if_q.size() < 2 && $urandom_range(0, 3) == 0)
                push_if($urandom & 32'hFF00_00FC, $urandom_range(0, 3));
            if (d_q.size() < 2 && $urandom_range(0, 2) == 0)
                push_d($urandom & 32'hFF00_00FC, $urandom_range(0, 1) == 1,
                       $urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 2));
            step(0);
        end
        wait_idle("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
